// File: rtl/spi_regfile_periph.sv
// spi_regfile_periph
// ------------------
// SPI mode 0 peripheral exposing NUM_REGS registers of DATA_W bits to an
// external SPI controller. Each frame is MSB first:
//   R/W (1 = write) | ADDR_W address bits | DATA_W data bits
// Writes are committed when nCS rises, and only for complete, in-range
// frames. Reads shift reg[addr] out on CIPO during the data phase.
//
// Handshake semantics: there is no valid/ready pair here. A write is
// "accepted" exactly when wr_strobe[i] pulses. A frame is "rejected"
// exactly when frame_err pulses. Both pulses are one clk cycle long.
//
// Ports:
//   clk       system clock, at least 8x SCLK
//   rst_n     asynchronous active-low reset
//   nCS       chip select, active low, asynchronous to clk
//   SCLK      SPI clock, idles low, asynchronous to clk
//   COPI      controller-out data
//   CIPO      peripheral-out data (0 whenever no read data is being shifted)
//   CIPO_oe   high while the synchronised nCS is low
//   reg_q     register contents; register i is bits [i*DATA_W +: DATA_W]
//   wr_strobe one-cycle pulse on bit i when register i is updated
//   frame_err one-cycle pulse when a frame is rejected
module spi_regfile_periph #(
    parameter int NUM_REGS    = 5,
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       nCS,
    input  logic                       SCLK,
    input  logic                       COPI,
    output logic                       CIPO,
    output logic                       CIPO_oe,
    output logic [NUM_REGS*DATA_W-1:0] reg_q,
    output logic [NUM_REGS-1:0]        wr_strobe,
    output logic                       frame_err
);

    localparam int FRAME_BITS = 1 + ADDR_W + DATA_W;
    localparam int CNT_W      = $clog2(FRAME_BITS + 2);

    localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0]  CNT_SAT    = CNT_W'(FRAME_BITS + 1);
    // Count value just before the rising edge that completes the header.
    localparam logic [CNT_W-1:0]  CNT_HDR    = CNT_W'(ADDR_W);
    localparam logic [ADDR_W:0]   NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);

    // Synchroniser chains: index 0 is the first stage. nCS and SCLK carry
    // one extra stage at index SYNC_STAGES for edge detection.
    logic [SYNC_STAGES:0]          ncs_sync_q,  ncs_sync_d;
    logic [SYNC_STAGES:0]          sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0]        copi_sync_q, copi_sync_d;

    logic [CNT_W-1:0]              cnt_q,       cnt_d;
    logic [FRAME_BITS-1:0]         rx_q,        rx_d;
    logic [DATA_W-1:0]             rd_q,        rd_d;
    logic                          cipo_q,      cipo_d;
    logic [NUM_REGS*DATA_W-1:0]    regs_q,      regs_d;
    logic [NUM_REGS-1:0]           wr_strobe_q, wr_strobe_d;
    logic                          frame_err_q, frame_err_d;

    logic                          ncs_s, ncs_fall, ncs_rise;
    logic                          sclk_rise, sclk_fall;
    logic                          copi_s;

    logic [ADDR_W:0]               hdr;
    logic [ADDR_W-1:0]             hdr_addr;
    logic [DATA_W-1:0]             rd_word;

    logic                          c_rw;
    logic [ADDR_W-1:0]             c_addr;
    logic [DATA_W-1:0]             c_data;
    logic                          c_in_range;

    assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
    assign ncs_fall  =  ncs_sync_q[SYNC_STAGES] & ~ncs_s;
    assign ncs_rise  = ~ncs_sync_q[SYNC_STAGES] &  ncs_s;
    assign sclk_rise =  sclk_sync_q[SYNC_STAGES-1] & ~sclk_sync_q[SYNC_STAGES];
    assign sclk_fall = ~sclk_sync_q[SYNC_STAGES-1] &  sclk_sync_q[SYNC_STAGES];
    assign copi_s    = copi_sync_q[SYNC_STAGES-1];

    // Header as it will look once the current COPI bit is shifted in; only
    // meaningful on the rising edge that completes the header.
    assign hdr       = {rx_q[ADDR_W-1:0], copi_s};
    assign hdr_addr  = hdr[ADDR_W-1:0];

    // Fields of a captured full frame, used at nCS deassert.
    assign c_rw       = rx_q[FRAME_BITS-1];
    assign c_addr     = rx_q[DATA_W +: ADDR_W];
    assign c_data     = rx_q[DATA_W-1:0];
    assign c_in_range = ({1'b0, c_addr} < NUM_REGS_W);

    // Read mux: out-of-range addresses never match and so return 0.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (hdr_addr == ADDR_W'(i)) begin
                rd_word = regs_q[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        ncs_sync_d  = {ncs_sync_q[SYNC_STAGES-1:0], nCS};
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-1:0], SCLK};
        copi_sync_d = {copi_sync_q[SYNC_STAGES-2:0], COPI};

        cnt_d       = cnt_q;
        rx_d        = rx_q;
        rd_d        = rd_q;
        cipo_d      = cipo_q;
        regs_d      = regs_q;
        wr_strobe_d = '0;
        frame_err_d = 1'b0;

        if (ncs_fall) begin
            cnt_d  = '0;
            rx_d   = '0;
            rd_d   = '0;
            cipo_d = 1'b0;
        end else if (!ncs_s) begin
            if (sclk_rise) begin
                rx_d = {rx_q[FRAME_BITS-2:0], copi_s};
                if (cnt_q != CNT_SAT) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if ((cnt_q == CNT_HDR) && !hdr[ADDR_W]) begin
                    rd_d = rd_word;
                end
            end else if (sclk_fall) begin
                cipo_d = rd_q[DATA_W-1];
                rd_d   = rd_q << 1;
            end
        end else begin
            cipo_d = 1'b0;
        end

        // Deassert decision uses only the captured frame, so a following
        // frame start cannot disturb it. A frame with no SCLK edges is silent.
        if (ncs_rise && (cnt_q != '0)) begin
            if (cnt_q != CNT_FULL) begin
                frame_err_d = 1'b1;
            end else if (c_rw) begin
                if (c_in_range) begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (c_addr == ADDR_W'(i)) begin
                            regs_d[i*DATA_W +: DATA_W] = c_data;
                            wr_strobe_d[i]             = 1'b1;
                        end
                    end
                end else begin
                    frame_err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ncs_sync_q  <= '1;
            sclk_sync_q <= '0;
            copi_sync_q <= '0;
            cnt_q       <= '0;
            rx_q        <= '0;
            rd_q        <= '0;
            cipo_q      <= 1'b0;
            regs_q      <= '0;
            wr_strobe_q <= '0;
            frame_err_q <= 1'b0;
        end else begin
            ncs_sync_q  <= ncs_sync_d;
            sclk_sync_q <= sclk_sync_d;
            copi_sync_q <= copi_sync_d;
            cnt_q       <= cnt_d;
            rx_q        <= rx_d;
            rd_q        <= rd_d;
            cipo_q      <= cipo_d;
            regs_q      <= regs_d;
            wr_strobe_q <= wr_strobe_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign CIPO      = cipo_q;
    assign CIPO_oe   = ~ncs_s;
    assign reg_q     = regs_q;
    assign wr_strobe = wr_strobe_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_regfile_periph.sv
// Testbench for spi_regfile_periph. Two instances share SCLK/COPI/rst_n:
// dut_a uses default parameters (16-bit frames), dut_b uses NUM_REGS=16,
// DATA_W=16, ADDR_W=4 (21-bit frames). Each has its own chip select.
module tb_spi_regfile_periph;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic sclk = 1'b0;
  logic copi = 1'b0;
  logic ncs_a = 1'b1;
  logic ncs_b = 1'b1;

  logic         cipo_a, oe_a, fe_a;
  logic [39:0]  reg_q_a;
  logic [4:0]   ws_a;
  logic         cipo_b, oe_b, fe_b;
  logic [255:0] reg_q_b;
  logic [15:0]  ws_b;

  spi_regfile_periph dut_a (
    .clk(clk), .rst_n(rst_n), .nCS(ncs_a), .SCLK(sclk), .COPI(copi),
    .CIPO(cipo_a), .CIPO_oe(oe_a), .reg_q(reg_q_a), .wr_strobe(ws_a),
    .frame_err(fe_a)
  );

  spi_regfile_periph #(.NUM_REGS(16), .DATA_W(16), .ADDR_W(4), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .nCS(ncs_b), .SCLK(sclk), .COPI(copi),
    .CIPO(cipo_b), .CIPO_oe(oe_b), .reg_q(reg_q_b), .wr_strobe(ws_b),
    .frame_err(fe_b)
  );

  // ---------------- reference model ----------------
  int n_checks = 0;
  int n_pass = 0;

  logic [15:0] mdl_a [16];
  logic [15:0] mdl_b [16];
  logic [15:0] exp_sa[$];
  logic [15:0] exp_sb[$];
  int exp_err_a, exp_err_b, obs_err_a, obs_err_b;

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      mdl_a[i] = '0;
      mdl_b[i] = '0;
    end
    exp_sa.delete();
    exp_sb.delete();
    exp_err_a = 0; exp_err_b = 0;
    obs_err_a = 0; obs_err_b = 0;
  endtask

  // Applies the frame rules to the model: returns whether read data is
  // expected and what it should be.
  task automatic model_frame(input int sel, input int nbits, input logic [31:0] word,
                             output logic rd_ok, output logic [15:0] rd_exp);
    int nr, dw, aw, fb, addr;
    logic rw;
    logic [15:0] data;
    nr = (sel == 0) ? 5 : 16;
    dw = (sel == 0) ? 8 : 16;
    aw = (sel == 0) ? 7 : 4;
    fb = 1 + aw + dw;
    rd_ok = 1'b0;
    rd_exp = '0;
    rw = word[fb-1];
    addr = int'((word >> dw) & ((32'd1 << aw) - 32'd1));
    data = 16'(word & ((32'd1 << dw) - 32'd1));
    if (nbits == 0) begin
      rd_ok = 1'b0;
    end else if (nbits != fb) begin
      if (sel == 0) exp_err_a++; else exp_err_b++;
    end else if (rw) begin
      if (addr < nr) begin
        if (sel == 0) begin
          mdl_a[addr] = data;
          exp_sa.push_back(16'd1 << addr);
        end else begin
          mdl_b[addr] = data;
          exp_sb.push_back(16'd1 << addr);
        end
      end else begin
        if (sel == 0) exp_err_a++; else exp_err_b++;
      end
    end else begin
      rd_ok = 1'b1;
      if (addr < nr) rd_exp = (sel == 0) ? mdl_a[addr] : mdl_b[addr];
    end
  endtask

  function automatic logic [39:0] flat_a();
    logic [39:0] r;
    for (int i = 0; i < 5; i++) r[i*8 +: 8] = mdl_a[i][7:0];
    return r;
  endfunction

  function automatic logic [255:0] flat_b();
    logic [255:0] r;
    for (int i = 0; i < 16; i++) r[i*16 +: 16] = mdl_b[i];
    return r;
  endfunction

  function automatic logic [31:0] mk_a(input logic rw, input logic [6:0] addr, input logic [7:0] data);
    return {16'h0, rw, addr, data};
  endfunction

  function automatic logic [31:0] mk_b(input logic rw, input logic [3:0] addr, input logic [15:0] data);
    return {11'h0, rw, addr, data};
  endfunction

  // ---------------- scoreboard: strobes and error pulses ----------------
  logic [15:0] sb_exp;
  always @(negedge clk) begin
    if (rst_n) begin
      if (ws_a != '0) begin
        n_checks++;
        if (exp_sa.size() == 0) begin
          $display("FAIL strobe_a: got %b, required no strobe", ws_a);
        end else begin
          sb_exp = exp_sa.pop_front();
          if (16'(ws_a) !== sb_exp) $display("FAIL strobe_a: got %b, required %b", ws_a, sb_exp[4:0]);
          else n_pass++;
        end
      end
      if (ws_b != '0) begin
        n_checks++;
        if (exp_sb.size() == 0) begin
          $display("FAIL strobe_b: got %h, required no strobe", ws_b);
        end else begin
          sb_exp = exp_sb.pop_front();
          if (ws_b !== sb_exp) $display("FAIL strobe_b: got %h, required %h", ws_b, sb_exp);
          else n_pass++;
        end
      end
      if (fe_a) obs_err_a++;
      if (fe_b) obs_err_b++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic spi_bit(input int sel, input logic b, output logic seen);
    copi = b;
    repeat (8) @(negedge clk);
    sclk = 1'b1;
    seen = (sel == 0) ? cipo_a : cipo_b;
    repeat (8) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic spi_frame(input int sel, input int nbits, input logic [31:0] word, input int gap,
                           output logic [31:0] miso, output logic oe_hi);
    logic s;
    miso = '0;
    oe_hi = 1'b1;
    if (sel == 0) ncs_a = 1'b0; else ncs_b = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = nbits - 1; i >= 0; i--) begin
      spi_bit(sel, word[i], s);
      miso = {miso[30:0], s};
      if (((sel == 0) ? oe_a : oe_b) !== 1'b1) oe_hi = 1'b0;
    end
    repeat (8) @(negedge clk);
    ncs_a = 1'b1;
    ncs_b = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic xfer(input int sel, input int nbits, input logic [31:0] word,
                      output logic [31:0] miso, output logic oe_hi,
                      output logic rd_ok, output logic [15:0] rd_exp);
    model_frame(sel, nbits, word, rd_ok, rd_exp);
    spi_frame(sel, nbits, word, 12, miso, oe_hi);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    n_checks++; if (reg_q_a !== 40'h0) $display("FAIL reset_reg_a: got %h, required 0", reg_q_a); else n_pass++;
    n_checks++; if (reg_q_b !== 256'h0) $display("FAIL reset_reg_b: got %h, required 0", reg_q_b); else n_pass++;
    n_checks++; if ({ws_a, ws_b} !== 21'h0) $display("FAIL reset_strobe: got %h, required 0", {ws_a, ws_b}); else n_pass++;
    n_checks++; if ({fe_a, fe_b} !== 2'b00) $display("FAIL reset_err: got %b, required 00", {fe_a, fe_b}); else n_pass++;
    n_checks++; if ({cipo_a, cipo_b, oe_a, oe_b} !== 4'b0) $display("FAIL reset_cipo: got %b, required 0000", {cipo_a, cipo_b, oe_a, oe_b}); else n_pass++;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++; if ({reg_q_a, oe_a, fe_a} !== 42'h0) $display("FAIL post_reset_a: got %h, required 0", {reg_q_a, oe_a, fe_a}); else n_pass++;
  endtask

  task automatic test_write();
    logic [31:0] m; logic oe, rok; logic [15:0] re;
    xfer(0, 16, mk_a(1'b1, 7'h04, 8'hA5), m, oe, rok, re);
    xfer(0, 16, mk_a(1'b1, 7'h00, 8'h3C), m, oe, rok, re);
    n_checks++; if (reg_q_a[39:32] !== 8'hA5) $display("FAIL write_r4: got %h, required a5", reg_q_a[39:32]); else n_pass++;
    n_checks++; if (reg_q_a[7:0] !== 8'h3C) $display("FAIL write_r0: got %h, required 3c", reg_q_a[7:0]); else n_pass++;
    n_checks++; if (reg_q_a !== flat_a()) $display("FAIL write_all: got %h, required %h", reg_q_a, flat_a()); else n_pass++;
    n_checks++; if (exp_sa.size() != 0) $display("FAIL write_strobes_missing: got %0d pending, required 0", exp_sa.size()); else n_pass++;
    n_checks++; if (obs_err_a !== exp_err_a) $display("FAIL write_err: got %0d, required %0d", obs_err_a, exp_err_a); else n_pass++;
    exp_sa.delete();
  endtask

  task automatic test_read_after_write();
    logic [31:0] m; logic oe, rok; logic [15:0] re;
    xfer(0, 16, mk_a(1'b1, 7'h02, 8'h5A), m, oe, rok, re);
    n_checks++; if (oe_a !== 1'b0) $display("FAIL oe_idle: got %b, required 0", oe_a); else n_pass++;
    xfer(0, 16, mk_a(1'b0, 7'h02, 8'h00), m, oe, rok, re);
    n_checks++; if (m[7:0] !== 8'h5A) $display("FAIL read_r2: got %h, required 5a", m[7:0]); else n_pass++;
    n_checks++; if (m[7:0] !== re[7:0]) $display("FAIL read_r2_model: got %h, required %h", m[7:0], re[7:0]); else n_pass++;
    n_checks++; if (m[15:8] !== 8'h00) $display("FAIL read_hdr_cipo: got %h, required 00", m[15:8]); else n_pass++;
    n_checks++; if (oe !== 1'b1) $display("FAIL oe_in_frame: got %b, required 1", oe); else n_pass++;
    n_checks++; if (oe_a !== 1'b0 || cipo_a !== 1'b0) $display("FAIL oe_after: got %b%b, required 00", oe_a, cipo_a); else n_pass++;
    n_checks++; if (reg_q_a !== flat_a()) $display("FAIL read_no_change: got %h, required %h", reg_q_a, flat_a()); else n_pass++;
    n_checks++; if (obs_err_a !== exp_err_a) $display("FAIL read_err: got %0d, required %0d", obs_err_a, exp_err_a); else n_pass++;
    exp_sa.delete();
  endtask

  task automatic test_out_of_range();
    logic [31:0] m; logic oe, rok; logic [15:0] re;
    int e0;
    e0 = obs_err_a;
    xfer(0, 16, mk_a(1'b1, 7'h05, 8'hFF), m, oe, rok, re);
    n_checks++; if (obs_err_a - e0 !== 1) $display("FAIL oor_write_err: got %0d pulses, required 1", obs_err_a - e0); else n_pass++;
    n_checks++; if (reg_q_a !== flat_a()) $display("FAIL oor_write_reg: got %h, required %h", reg_q_a, flat_a()); else n_pass++;
    xfer(0, 16, mk_a(1'b0, 7'h7F, 8'h00), m, oe, rok, re);
    n_checks++; if (m[7:0] !== 8'h00 || re !== 16'h0) $display("FAIL oor_read_data: got %h, required 00", m[7:0]); else n_pass++;
    n_checks++; if (obs_err_a !== exp_err_a) $display("FAIL oor_read_err: got %0d, required %0d", obs_err_a, exp_err_a); else n_pass++;
    n_checks++; if (exp_sa.size() != 0) $display("FAIL oor_strobe: got %0d pending, required 0", exp_sa.size()); else n_pass++;
    exp_sa.delete();
  endtask

  task automatic test_malformed();
    logic [31:0] m; logic oe, rok; logic [15:0] re;
    int e0;
    e0 = obs_err_a;
    xfer(0, 12, {20'h0, 1'b1, 7'h01, 4'hF}, m, oe, rok, re);
    n_checks++; if (obs_err_a - e0 !== 1) $display("FAIL short_err: got %0d pulses, required 1", obs_err_a - e0); else n_pass++;
    xfer(0, 17, {15'h0, 1'b1, 7'h01, 8'hEE, 1'b1}, m, oe, rok, re);
    n_checks++; if (obs_err_a - e0 !== 2) $display("FAIL long_err: got %0d pulses, required 2", obs_err_a - e0); else n_pass++;
    n_checks++; if (reg_q_a !== flat_a()) $display("FAIL malformed_reg: got %h, required %h", reg_q_a, flat_a()); else n_pass++;
  endtask

  task automatic test_abort();
    logic [31:0] m; logic oe, rok; logic [15:0] re;
    ncs_a = 1'b0;
    repeat (10) @(negedge clk);
    ncs_a = 1'b1;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      copi = 1'b1;
      sclk = 1'b1; repeat (8) @(negedge clk);
      sclk = 1'b0; repeat (8) @(negedge clk);
    end
    n_checks++; if (obs_err_a !== exp_err_a) $display("FAIL abort_err: got %0d, required %0d", obs_err_a, exp_err_a); else n_pass++;
    n_checks++; if (reg_q_a !== flat_a()) $display("FAIL abort_reg: got %h, required %h", reg_q_a, flat_a()); else n_pass++;
    xfer(0, 16, mk_a(1'b1, 7'h01, 8'h77), m, oe, rok, re);
    n_checks++; if (reg_q_a !== flat_a()) $display("FAIL abort_then_write: got %h, required %h", reg_q_a, flat_a()); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] m; logic oe, rok; logic [15:0] re; logic s;
    xfer(0, 16, mk_a(1'b1, 7'h03, 8'h81), m, oe, rok, re);
    n_checks++; if (reg_q_a[31:24] !== 8'h81) $display("FAIL pre_reset_r3: got %h, required 81", reg_q_a[31:24]); else n_pass++;
    ncs_a = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 6; i++) spi_bit(0, 1'b1, s);
    copi = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if (reg_q_a !== 40'h0) $display("FAIL midreset_reg: got %h, required 0", reg_q_a); else n_pass++;
    n_checks++; if ({oe_a, cipo_a, ws_a, fe_a} !== 8'h0) $display("FAIL midreset_out: got %b, required 0", {oe_a, cipo_a, ws_a, fe_a}); else n_pass++;
    model_clear();
    ncs_a = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    xfer(0, 16, mk_a(1'b1, 7'h01, 8'hC3), m, oe, rok, re);
    n_checks++; if (reg_q_a !== 40'h00_0000_C300) $display("FAIL after_reset_write: got %h, required 000000c300", reg_q_a); else n_pass++;
    n_checks++; if (exp_sa.size() != 0) $display("FAIL after_reset_strobe: got %0d pending, required 0", exp_sa.size()); else n_pass++;
    exp_sa.delete();
  endtask

  task automatic test_back_to_back();
    logic [31:0] m; logic oe, rok; logic [15:0] re;
    model_frame(0, 16, mk_a(1'b1, 7'h02, 8'h11), rok, re);
    spi_frame(0, 16, mk_a(1'b1, 7'h02, 8'h11), 4, m, oe);
    model_frame(0, 16, mk_a(1'b1, 7'h04, 8'h22), rok, re);
    spi_frame(0, 16, mk_a(1'b1, 7'h04, 8'h22), 4, m, oe);
    model_frame(0, 16, mk_a(1'b0, 7'h02, 8'h00), rok, re);
    spi_frame(0, 16, mk_a(1'b0, 7'h02, 8'h00), 12, m, oe);
    n_checks++; if (reg_q_a !== flat_a()) $display("FAIL b2b_reg: got %h, required %h", reg_q_a, flat_a()); else n_pass++;
    n_checks++; if (m[7:0] !== re[7:0]) $display("FAIL b2b_read: got %h, required %h", m[7:0], re[7:0]); else n_pass++;
    n_checks++; if (exp_sa.size() != 0) $display("FAIL b2b_strobe: got %0d pending, required 0", exp_sa.size()); else n_pass++;
    exp_sa.delete();
  endtask

  task automatic test_param_sweep();
    logic [31:0] m; logic oe, rok; logic [15:0] re;
    for (int i = 0; i < 16; i++) xfer(1, 21, mk_b(1'b1, 4'(i), 16'hC000 | 16'(i)), m, oe, rok, re);
    n_checks++; if (reg_q_b !== flat_b()) $display("FAIL sweep_regs: got %h, required %h", reg_q_b, flat_b()); else n_pass++;
    n_checks++; if (exp_sb.size() != 0) $display("FAIL sweep_strobes: got %0d pending, required 0", exp_sb.size()); else n_pass++;
    for (int i = 0; i < 16; i++) begin
      xfer(1, 21, mk_b(1'b0, 4'(i), 16'h0), m, oe, rok, re);
      n_checks++;
      if (m[15:0] !== (16'hC000 | 16'(i)) || m[15:0] !== re)
        $display("FAIL sweep_read_%0d: got %h, required %h", i, m[15:0], re);
      else n_pass++;
    end
    n_checks++; if (obs_err_b !== exp_err_b || reg_q_a !== flat_a()) $display("FAIL sweep_side: err %0d, required %0d", obs_err_b, exp_err_b); else n_pass++;
    exp_sb.delete();
  endtask

  task automatic test_random();
    logic [31:0] m, w; logic oe, rok; logic [15:0] re;
    int kind, nb;
    for (int k = 0; k < 24; k++) begin
      kind = $urandom_range(0, 5);
      w = mk_a(1'($urandom_range(0, 1)), 7'($urandom_range(0, 6)), 8'($urandom));
      nb = 16;
      if (kind == 3) begin nb = 12; w = w >> 4; end
      if (kind == 4) begin nb = 17; w = {w[30:0], 1'($urandom)}; end
      xfer(0, nb, w, m, oe, rok, re);
      n_checks++; if (reg_q_a !== flat_a()) $display("FAIL rand_reg_%0d: got %h, required %h", k, reg_q_a, flat_a()); else n_pass++;
      n_checks++; if (obs_err_a !== exp_err_a) $display("FAIL rand_err_%0d: got %0d, required %0d", k, obs_err_a, exp_err_a); else n_pass++;
      if (rok) begin
        n_checks++; if (m[7:0] !== re[7:0]) $display("FAIL rand_read_%0d: got %h, required %h", k, m[7:0], re[7:0]); else n_pass++;
      end
    end
    n_checks++; if (exp_sa.size() != 0) $display("FAIL rand_strobes: got %0d pending, required 0", exp_sa.size()); else n_pass++;
    exp_sa.delete();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_write();
    test_read_after_write();
    test_out_of_range();
    test_malformed();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_param_sweep();
    test_random();
    repeat (10) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL timeout: simulation reached 800 us without finishing");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "timeout");
  end

endmodule
